param_single_port_ram: RTL and testbench
========================================

Name: param_single_port_ram

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 8x8 single-port RAM.
- Adds configurable width/depth, per-byte write enables, selectable read-during-write mode and an optional output pipeline register.
- Adds a post-reset clear sequencer that zeroes every word before accepting accesses.
- Used as a local scratch/buffer memory behind simple register-style masters.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8
ADDR_W, 3, address width
DEPTH, 2**ADDR_W, number of words; 1 <= DEPTH <= 2**ADDR_W
RDW_MODE, 0, read-during-write: 0 = old data (read-first), 1 = new merged data (write-first)
OUT_REG, 0, 0 = 1-cycle read latency, 1 = 2-cycle latency (extra output register)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  access enable
wr  input  1  1 = write, 0 = read (qualified by en)
be  input  DATA_W/8  byte write enables; bit i covers din[8i+7:8i]
add  input  ADDR_W  word address
din  input  DATA_W  write data
dout  output  DATA_W  read data
dout_valid  output  1  one-cycle pulse; dout updated this cycle
busy  output  1  high while clear sweep runs; accesses ignored

Behaviour:
- Reset (async assert, sync release):
  - dout=0, dout_valid=0, busy=1.
  - FSM goes to CLEAR; clear counter=0; output pipeline flushed.
- FSM states: CLEAR and READY.
  - CLEAR: each cycle write 0 to mem[cnt], cnt++; when cnt==DEPTH-1 the write completes and the FSM enters READY next cycle.
  - CLEAR takes exactly DEPTH cycles after reset release. busy=1 throughout; en/wr/be/add/din are ignored.
  - READY: busy=0. The FSM stays in READY until the next reset.
- Reset asserted mid-CLEAR or mid-access: sweep restarts from 0 and in-flight reads are discarded (no dout_valid).
- Write (READY, en=1, wr=1):
  - For each byte lane i with be[i]=1, mem[add] lane i <= din lane i; other lanes unchanged.
  - Write access also returns data. RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns the merged post-write word.
  - be all zero: memory unchanged; data is still returned per mode.
- Read (READY, en=1, wr=0): returns mem[add].
- Latency: access sampled at edge N.
  - OUT_REG=0: dout and dout_valid update at edge N+1.
  - OUT_REG=1: dout and dout_valid update at edge N+2.
  - Back-to-back accesses are fully pipelined, one per cycle.
- No access (en=0 or busy=1): dout holds its last value; dout_valid=0 for the corresponding slot.
- Out-of-range address (add >= DEPTH): write ignored; read returns 0 with dout_valid=1.
- Read after write to the same address on the next cycle returns the new data in both modes.

Optional Feature:
- Macro: PARITY_SINGLE_PORT_RAM_EN.
- When defined, the RAM stores one even-parity bit per byte lane, computed at write time. The clear sweep stores parity 0.
- Extra ports when defined:
  - par_inj input 1: when high during a write, the stored parity bits of all written lanes are inverted.
  - par_err output 1: valid with dout_valid; high if any lane's recomputed parity mismatches the stored parity. Reset value 0.
- Pipeline: par_err follows the same pipeline as dout.
- Out-of-range reads: par_err=0.
- When not defined: no parity storage, no par_inj/par_err ports, no added logic.

Test Plan:
- Clear sweep: defaults; reset, then release → busy=1 for exactly 8 cycles, then 0. Read all 8 addresses → dout=8'h00 each, dout_valid pulse per read.
- Basic write/read, defaults: write 8'h4B@1, 8'h6F@2, 8'h55@4, 8'h15@7, then read 1,2,4,7 back-to-back → dout = 4B,6F,55,15, one cycle after each read, with continuous dout_valid.
- Byte enables, DATA_W=16: write 16'hAAAA@3 with be=2'b11, then 16'h1234@3 with be=2'b01, read 3 → 16'hAA34.
- Read-during-write: mem[5]=8'h11; write 8'h22@5 → dout=8'h11 with RDW_MODE=0 and 8'h22 with RDW_MODE=1. A read of 5 next cycle → 8'h22 in both modes.
- OUT_REG=1, reset mid-access:
  - Read @1 (8'h4B) → dout_valid at edge N+2.
  - Assert rst between N+1 and N+2 → dout=0, no valid pulse, busy=1, clear sweep restarts.
- With PARITY_SINGLE_PORT_RAM_EN: write 8'h4B@0 with par_inj=1, 8'h4B@6 with par_inj=0; read 0 → par_err=1; read 6 → par_err=0.

Source files
------------

// File: rtl/param_single_port_ram.sv
// param_single_port_ram: parametrised single-port RAM with byte enables, clear sweep and optional lane parity (macro PARITY_SINGLE_PORT_RAM_EN)
module param_single_port_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     add,
  input  logic [DATA_W-1:0]     din,
`ifdef PARITY_SINGLE_PORT_RAM_EN
  input  logic                  par_inj,
  output logic                  par_err,
`endif
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy
);
  localparam int NB = DATA_W/8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic req_v_q, req_wr_q;
  logic [NB-1:0] req_be_q;
  logic [ADDR_W-1:0] req_add_q;
  logic [DATA_W-1:0] req_din_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic in_rng, mem_we;
  logic [DATA_W-1:0] old_w, new_w, ret_w;
  logic v1_q, v2_q;
  logic [DATA_W-1:0] d1_q, d2_q;
  assign busy = state_q == CLEAR;
  // Clear sweep visits every word once, then parks in READY until the next reset
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? READY : CLEAR;
    end
  end
  // Access stage: current word, byte-merged word and the word handed back to the master
  always_comb begin
    in_rng = {1'b0, req_add_q} < DEPTH_L;
    old_w = in_rng ? mem_q[req_add_q] : '0;
    new_w = old_w;
    for (int i = 0; i < NB; i++)
      if (req_be_q[i]) new_w[8*i +: 8] = req_din_q[8*i +: 8];
    ret_w = in_rng ? ((RDW_MODE != 0) ? new_w : old_w) : '0;
    mem_we = req_v_q & req_wr_q & in_rng;
  end
  // Storage: the sweep zeroes one word per cycle, afterwards byte-merged writes land here
  always_ff @(posedge clk) begin
    if (busy) mem_q[cnt_q] <= '0;
    else if (mem_we) mem_q[req_add_q] <= new_w;
  end
  // Control state, registered request and output pipeline; reset flushes anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      req_v_q <= 1'b0;
      req_wr_q <= 1'b0;
      req_be_q <= '0;
      req_add_q <= '0;
      req_din_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_v_q <= en & ~busy;
      req_wr_q <= wr;
      req_be_q <= be;
      req_add_q <= add;
      req_din_q <= din;
      v1_q <= req_v_q;
      v2_q <= v1_q;
      if (req_v_q) d1_q <= ret_w;
      if (v1_q) d2_q <= d1_q;
    end
  end
  assign dout = (OUT_REG != 0) ? d2_q : d1_q;
  assign dout_valid = (OUT_REG != 0) ? v2_q : v1_q;
`ifdef PARITY_SINGLE_PORT_RAM_EN
  logic req_inj_q, e1_q, e2_q;
  logic [NB-1:0] par_mem_q [DEPTH];
  logic [NB-1:0] old_p, new_p, ret_p, chk_p;
  // Lane parity follows the data merge; the returned word is re-checked against its stored parity
  always_comb begin
    old_p = in_rng ? par_mem_q[req_add_q] : '0;
    new_p = old_p;
    chk_p = '0;
    for (int i = 0; i < NB; i++) begin
      if (req_be_q[i]) new_p[i] = (^req_din_q[8*i +: 8]) ^ req_inj_q;
      chk_p[i] = ^ret_w[8*i +: 8];
    end
    ret_p = in_rng ? ((RDW_MODE != 0) ? new_p : old_p) : '0;
  end
  // Parity storage mirrors the data array, sweep stores zero parity
  always_ff @(posedge clk) begin
    if (busy) par_mem_q[cnt_q] <= '0;
    else if (mem_we) par_mem_q[req_add_q] <= new_p;
  end
  // Parity error travels the same pipeline as dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_inj_q <= 1'b0;
      e1_q <= 1'b0;
      e2_q <= 1'b0;
    end else begin
      req_inj_q <= par_inj;
      if (req_v_q) e1_q <= |(ret_p ^ chk_p);
      if (v1_q) e2_q <= e1_q;
    end
  end
  assign par_err = (OUT_REG != 0) ? e2_q : e1_q;
`endif
endmodule

// File: tb/tb_param_single_port_ram.sv
// tb_param_single_port_ram: four RAM configurations against one behavioural memory model plus literal checks
module tb_param_single_port_ram;
  localparam int DW_P[4] = '{8, 8, 8, 16};
  localparam int RW_P[4] = '{0, 1, 0, 0};
  localparam int OR_P[4] = '{0, 0, 1, 0};
  localparam int DP_P[4] = '{8, 8, 8, 6};
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, wr = 1'b0, par_inj = 1'b0;
  logic [1:0] be = '0;
  logic [2:0] add = '0;
  logic [15:0] din = '0;
  logic [7:0] d0, d1, d2;
  logic [15:0] d3;
  logic [3:0] v, bz, pe;
  logic [15:0] dout_a [4];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign dout_a[0] = {8'h00, d0};
  assign dout_a[1] = {8'h00, d1};
  assign dout_a[2] = {8'h00, d2};
  assign dout_a[3] = d3;
  param_single_port_ram u0 (.clk(clk), .rst(rst), .en(en), .wr(wr), .be(be[0:0]), .add(add), .din(din[7:0]),
`ifdef PARITY_SINGLE_PORT_RAM_EN
    .par_inj(par_inj), .par_err(pe[0]),
`endif
    .dout(d0), .dout_valid(v[0]), .busy(bz[0]));
  param_single_port_ram #(.RDW_MODE(1)) u1 (.clk(clk), .rst(rst), .en(en), .wr(wr), .be(be[0:0]), .add(add), .din(din[7:0]),
`ifdef PARITY_SINGLE_PORT_RAM_EN
    .par_inj(par_inj), .par_err(pe[1]),
`endif
    .dout(d1), .dout_valid(v[1]), .busy(bz[1]));
  param_single_port_ram #(.OUT_REG(1)) u2 (.clk(clk), .rst(rst), .en(en), .wr(wr), .be(be[0:0]), .add(add), .din(din[7:0]),
`ifdef PARITY_SINGLE_PORT_RAM_EN
    .par_inj(par_inj), .par_err(pe[2]),
`endif
    .dout(d2), .dout_valid(v[2]), .busy(bz[2]));
  param_single_port_ram #(.DATA_W(16), .DEPTH(6)) u3 (.clk(clk), .rst(rst), .en(en), .wr(wr), .be(be), .add(add), .din(din),
`ifdef PARITY_SINGLE_PORT_RAM_EN
    .par_inj(par_inj), .par_err(pe[3]),
`endif
    .dout(d3), .dout_valid(v[3]), .busy(bz[3]));
`ifndef PARITY_SINGLE_PORT_RAM_EN
  assign pe = '0;
`endif
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Behavioural model: plain word arrays, result slots delayed by the configured latency
  typedef struct packed {logic v; logic k; logic e; logic [15:0] d;} slot_t;
  int rel;
  logic [15:0] mm [4][8];
  logic [1:0] pm [4][8];
  slot_t pipe [4][2];
  logic [3:0] ev, ek, ee;
  logic [15:0] ed [4];
  function automatic slot_t access(input int k);
    slot_t s;
    logic [15:0] old, nw;
    logic [1:0] op, np, rp;
    int a;
    bit rng;
    a = int'(add);
    rng = a < DP_P[k];
    old = rng ? mm[k][a] : 16'h0;
    op = rng ? pm[k][a] : 2'b0;
    nw = old;
    np = op;
    for (int i = 0; i < DW_P[k]/8; i++)
      if (be[i]) begin
        nw[8*i +: 8] = din[8*i +: 8];
        np[i] = (^din[8*i +: 8]) ^ par_inj;
      end
    if (rng && wr) begin
      mm[k][a] = nw;
      pm[k][a] = np;
    end
    s.v = 1'b1;
    s.k = rng || !wr;
    s.d = !rng ? 16'h0 : (RW_P[k] != 0 ? nw : old);
    rp = !rng ? 2'b0 : (RW_P[k] != 0 ? np : op);
    s.e = 1'b0;
    for (int i = 0; i < DW_P[k]/8; i++)
      if (rp[i] != ^s.d[8*i +: 8]) s.e = 1'b1;
    return s;
  endfunction
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        rel = 0;
        ev = '0;
        ee = '0;
        ek = '1;
        for (int k = 0; k < 4; k++) begin
          ed[k] = '0;
          pipe[k][0] = '0;
          pipe[k][1] = '0;
          for (int a = 0; a < 8; a++) begin
            mm[k][a] = '0;
            pm[k][a] = '0;
          end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          ev[k] = pipe[k][0].v;
          if (pipe[k][0].v) begin
            ed[k] = pipe[k][0].d;
            ek[k] = pipe[k][0].k;
            ee[k] = pipe[k][0].e;
          end
          pipe[k][0] = pipe[k][1];
          pipe[k][1] = '0;
          if (en && rel >= DP_P[k]) pipe[k][OR_P[k]] = access(k);
        end
        rel++;
      end
    end
  end
  // Compare process: every cycle, every instance, on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("busy%0d", k), {15'b0, bz[k]}, {15'b0, rel < DP_P[k]});
        chk($sformatf("valid%0d", k), {15'b0, v[k]}, {15'b0, ev[k]});
        if (ek[k]) chk($sformatf("dout%0d", k), dout_a[k], ed[k]);
`ifdef PARITY_SINGLE_PORT_RAM_EN
        if (ek[k]) chk($sformatf("par_err%0d", k), {15'b0, pe[k]}, {15'b0, ee[k]});
`endif
      end
    end
  end
  task automatic cyc(input logic e, input logic w, input logic [1:0] b, input logic [2:0] a, input logic [15:0] d);
    en = e;
    wr = w;
    be = b;
    add = a;
    din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input string name);
    int nb = 0;
    for (int i = 0; i < 12; i++) begin
      nb += int'(bz[0]);
      cyc(i < 8, 1'b1, 2'b11, 3'(i), 16'hFFFF);
    end
    chk(name, 16'(nb), 16'd8);
  endtask
  initial begin
    int nv;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sweep("busy_cycles");
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(i < 8, 1'b0, 2'b00, 3'(i), 16'h0);
      nv += int'(v[0]);
    end
    chk("clear_valids", 16'(nv), 16'd8);
    chk("clear_dout", dout_a[0], 16'h0000);
    cyc(1, 1, 2'b11, 3'd1, 16'hB44B);
    cyc(1, 1, 2'b11, 3'd2, 16'h906F);
    cyc(1, 1, 2'b11, 3'd4, 16'hAA55);
    cyc(1, 1, 2'b11, 3'd7, 16'hEA15);
    cyc(1, 0, 2'b00, 3'd1, 16'h0);
    cyc(1, 0, 2'b00, 3'd2, 16'h0);
    chk("rd1", dout_a[0], 16'h004B);
    chk("rd1_w16", dout_a[3], 16'hB44B);
    cyc(1, 0, 2'b00, 3'd4, 16'h0);
    chk("rd2", dout_a[0], 16'h006F);
    cyc(1, 0, 2'b00, 3'd7, 16'h0);
    chk("rd4", dout_a[0], 16'h0055);
    chk("rd_valid", {15'b0, v[0]}, 16'd1);
    cyc(0, 0, 2'b00, 3'd0, 16'h0);
    chk("rd7", dout_a[0], 16'h0015);
    chk("oor_rd", dout_a[3], 16'h0000);
    chk("oor_valid", {15'b0, v[3]}, 16'd1);
    cyc(1, 1, 2'b11, 3'd3, 16'hAAAA);
    cyc(1, 1, 2'b01, 3'd3, 16'h1234);
    cyc(1, 0, 2'b00, 3'd3, 16'h0);
    cyc(0, 0, 2'b00, 3'd0, 16'h0);
    chk("be_merge", dout_a[3], 16'hAA34);
    chk("be_merge8", dout_a[0], 16'h0034);
    cyc(1, 1, 2'b11, 3'd5, 16'h0011);
    cyc(1, 1, 2'b11, 3'd5, 16'h0022);
    cyc(1, 0, 2'b00, 3'd5, 16'h0);
    chk("rdw_old", dout_a[0], 16'h0011);
    chk("rdw_new", dout_a[1], 16'h0022);
    cyc(0, 0, 2'b00, 3'd0, 16'h0);
    chk("raw_mode0", dout_a[0], 16'h0022);
    chk("raw_mode1", dout_a[1], 16'h0022);
    cyc(1, 0, 2'b00, 3'd1, 16'h0);
    cyc(0, 0, 2'b00, 3'd0, 16'h0);
    chk("or0_lat", dout_a[0], 16'h004B);
    chk("or1_hold", dout_a[2], 16'h0022);
    chk("or1_pending", {15'b0, v[2]}, 16'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_dout", dout_a[2], 16'h0000);
    chk("rst_busy", {15'b0, bz[2]}, 16'd1);
    @(posedge clk);
    #1;
    chk("rst_no_valid", {15'b0, v[2]}, 16'd0);
    rst = 1'b0;
    sweep("busy_cycles_again");
`ifdef PARITY_SINGLE_PORT_RAM_EN
    par_inj = 1'b1;
    cyc(1, 1, 2'b11, 3'd0, 16'h004B);
    par_inj = 1'b0;
    cyc(1, 1, 2'b11, 3'd6, 16'h004B);
    cyc(1, 0, 2'b00, 3'd0, 16'h0);
    cyc(1, 0, 2'b00, 3'd6, 16'h0);
    chk("par_inj", {15'b0, pe[0]}, 16'd1);
    cyc(0, 0, 2'b00, 3'd0, 16'h0);
    chk("par_ok", {15'b0, pe[0]}, 16'd0);
`endif
    repeat (4) cyc(0, 0, 2'b00, 3'd0, 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
